// File: rtl/mem_pkg.sv
// Shared constants and loader state type for the boot instruction memory.
package mem_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } load_state_e;

endpackage

// File: rtl/instr_loader_fsm.sv
// Program loader control: owns the load state, the accepted-word count and
// the valid/ready handshake; tells the storage where the next word goes.
module instr_loader_fsm
    import mem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clk_enable_i,
    input  logic                     load_valid_i,
    input  logic                     load_last_i,
    output logic                     load_ready_o,
    output logic                     prog_ready_o,
    output logic [$clog2(DEPTH):0]   words_loaded_o,
    output logic                     wr_en_o,
    output logic [$clog2(DEPTH)-1:0] wr_idx_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    load_state_e   state_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          accept;
    logic          final_word;

    // Reset is gated in so a word offered during reset never reaches storage.
    assign accept     = clk_enable_i && load_valid_i && (state_q != READY) && !reset_i;
    assign count_d    = count_q + 1'b1;
    assign final_word = load_last_i || (count_d == CW'(DEPTH));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_d;
            state_q <= final_word ? READY : LOAD;
        end
    end

    assign load_ready_o   = (state_q != READY);
    assign prog_ready_o   = (state_q == READY);
    assign words_loaded_o = count_q;
    assign wr_en_o        = accept;
    assign wr_idx_o       = count_q[AW-1:0];

endmodule

// File: rtl/instr_memory.sv
// Boot instruction memory: filled once by a streaming loader, then serves
// combinational CPU fetches relative to BASE with a sticky illegal-fetch flag.
module instr_memory
    import mem_pkg::*;
#(
    parameter int          DEPTH = 64,
    parameter logic [31:0] BASE  = RESET_VECTOR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_enable,
    input  logic                   load_valid,
    input  logic [31:0]            load_data,
    input  logic                   load_last,
    output logic                   load_ready,
    input  logic [31:0]            instr_address,
    output logic [31:0]            instr_readdata,
    output logic                   prog_ready,
    output logic                   addr_fault,
    output logic [$clog2(DEPTH):0] words_loaded
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   index;
    logic          is_halt;
    logic          misaligned;
    logic          out_of_range;
    logic          hit;
    logic          addr_fault_q;

    instr_loader_fsm #(
        .DEPTH(DEPTH)
    ) u_loader (
        .clk_i          (clk),
        .reset_i        (reset),
        .clk_enable_i   (clk_enable),
        .load_valid_i   (load_valid),
        .load_last_i    (load_last),
        .load_ready_o   (load_ready),
        .prog_ready_o   (prog_ready),
        .words_loaded_o (words_loaded),
        .wr_en_o        (wr_en),
        .wr_idx_o       (wr_idx)
    );

    // Storage is deliberately left uncleared; stale words are hidden by the count gate.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= load_data;
        end
    end

    assign index        = (instr_address - BASE) >> 2;
    assign is_halt      = (instr_address == HALT_ADDR);
    assign misaligned   = (instr_address[1:0] != 2'b00);
    assign out_of_range = (index >= 32'(DEPTH));
    assign hit          = prog_ready && !is_halt && !misaligned && (index < 32'(words_loaded));

    assign instr_readdata = hit ? mem[index[AW-1:0]] : NOP;

    // Fault only counts once the program is live; the halt address is always legal.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_fault_q <= 1'b0;
        end else if (clk_enable && prog_ready && !is_halt && (misaligned || out_of_range)) begin
            addr_fault_q <= 1'b1;
        end
    end

    assign addr_fault = addr_fault_q;

endmodule

// File: tb/tb_instr_memory.sv
// Directed-plus-random bench for instr_memory against an address-arithmetic
// reference of the load protocol and fetch rules.
module tb_instr_memory;
    import mem_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = RESET_VECTOR;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        prog_ready;
    logic        addr_fault;
    logic [6:0]  words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] mMem [DEPTH];
    int          mCount;
    bit          mReady;
    bit          mFault;

    logic [31:0] words [70];
    logic [31:0] stallWords [4];

    instr_memory #(
        .DEPTH(DEPTH),
        .BASE (BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_last      (load_last),
        .load_ready     (load_ready),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .prog_ready     (prog_ready),
        .addr_fault     (addr_fault),
        .words_loaded   (words_loaded)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] refRead(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (!mReady || a == HALT_ADDR || (a % 4) != 0) return NOP;
        if ((off / 4) < 32'(mCount)) return mMem[off / 4];
        return NOP;
    endfunction

    function automatic bit refFault(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return mReady && (a != HALT_ADDR) && (((a % 4) != 0) || ((off / 4) >= 32'(DEPTH)));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("load_ready", 32'(load_ready), 32'(!mReady));
        check("prog_ready", 32'(prog_ready), 32'(mReady));
        check("words_loaded", 32'(words_loaded), 32'(mCount));
        check("addr_fault", 32'(addr_fault), 32'(mFault));
        check("readdata", instr_readdata, refRead(instr_address));
    endtask

    // One clock: drive, compare pre-edge outputs, advance the reference, cross the edge.
    task automatic applyStimulus(input bit rst, input bit en, input bit valid, input bit last,
                                 input logic [31:0] data, input logic [31:0] addr);
        reset         = rst;
        clk_enable    = en;
        load_valid    = valid;
        load_last     = last;
        load_data     = data;
        instr_address = addr;
        #1;
        checkOutput();
        if (rst) begin
            mCount = 0;
            mReady = 0;
            mFault = 0;
        end else if (en) begin
            if (refFault(addr)) mFault = 1;
            if (valid && !mReady) begin
                mMem[mCount] = data;
                mCount++;
                if (last || mCount == DEPTH) mReady = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetchExpect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        applyStimulus(0, 1, 0, 0, $urandom, addr);
        check(tag, instr_readdata, exp);
    endtask

    task automatic randomAddr(output logic [31:0] a);
        case ($urandom_range(0, 4))
            0: a = BASE + 32'(4 * $urandom_range(0, 70));
            1: a = BASE + 32'($urandom_range(0, 280));
            2: a = HALT_ADDR;
            3: a = $urandom;
            default: a = BASE - 32'(4 * $urandom_range(1, 4));
        endcase
    endtask

    initial begin
        logic [31:0] addr;

        reset         = 1'b1;
        clk_enable    = 1'b0;
        load_valid    = 1'b1;
        load_last     = 1'b0;
        load_data     = 32'h0;
        instr_address = BASE;
        @(posedge clk);
        #1;
        mCount = 0;
        mReady = 0;
        mFault = 0;
        check("reset_words", 32'(words_loaded), 32'd0);
        check("reset_ready", 32'(load_ready), 32'd1);

        // Fetch before the program exists: NOP and no fault.
        applyStimulus(0, 1, 0, 0, 32'h0, BASE);
        applyStimulus(0, 1, 0, 0, 32'h0, BASE);
        check("early_fault", 32'(addr_fault), 32'd0);

        // Stalled loader: only enabled edges take a word.
        for (int i = 0; i < 8; i++) begin
            words[i] = $urandom;
            if (i % 2 == 0) stallWords[i / 2] = words[i];
            applyStimulus(0, (i % 2 == 0), 1, 0, words[i], BASE);
        end
        check("stall_count", 32'(words_loaded), 32'd4);
        applyStimulus(0, 1, 1, 1, $urandom, BASE);
        for (int k = 0; k < 4; k++) fetchExpect("stall_word", BASE + 32'(4 * k), stallWords[k]);

        // Reset wins over a disabled clock and a pending word.
        applyStimulus(1, 0, 1, 0, $urandom, BASE);
        check("rst_dominates", 32'(words_loaded), 32'd0);

        // Partial program discarded by reset, then a short reload.
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, $urandom, BASE);
        applyStimulus(1, 1, 0, 0, 32'h0, BASE);
        check("midload_reset", 32'(words_loaded), 32'd0);
        for (int i = 0; i < 3; i++) begin
            words[i] = $urandom;
            applyStimulus(0, 1, 1, (i == 2), words[i], BASE);
        end
        fetchExpect("reload_w0", BASE, words[0]);
        fetchExpect("reload_w2", BASE + 32'h8, words[2]);
        fetchExpect("reload_gap", BASE + 32'hC, NOP);
        check("gap_nofault", 32'(addr_fault), 32'd0);
        applyStimulus(0, 0, 0, 0, 32'h0, BASE + 32'h100);
        check("stalled_nofault", 32'(addr_fault), 32'd0);
        applyStimulus(0, 1, 0, 0, 32'h0, BASE + 32'h100);
        check("range_fault", 32'(addr_fault), 32'd1);

        // Sixteen-word program terminated by load_last.
        applyStimulus(1, 0, 0, 0, 32'h0, BASE);
        for (int i = 0; i < 16; i++) begin
            words[i] = (i == 0) ? 32'h2401_0020 : $urandom;
            applyStimulus(0, 1, 1, (i == 15), words[i], BASE);
            if (i == 14) check("not_ready_yet", 32'(prog_ready), 32'd0);
        end
        check("load16_count", 32'(words_loaded), 32'd16);
        check("load16_ready", 32'(prog_ready), 32'd1);
        fetchExpect("fetch_w2", BASE + 32'h8, words[2]);
        fetchExpect("halt_fetch", HALT_ADDR, NOP);
        check("halt_nofault", 32'(addr_fault), 32'd0);
        fetchExpect("unloaded_fetch", BASE + 32'h40, NOP);
        check("unloaded_nofault", 32'(addr_fault), 32'd0);
        fetchExpect("misaligned_fetch", BASE + 32'h2, NOP);
        check("misaligned_fault", 32'(addr_fault), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, $urandom, BASE + 32'h3C);
        check("ready_holds", 32'(words_loaded), 32'd16);
        fetchExpect("fetch_w15", BASE + 32'h3C, words[15]);

        // Overflow: 70 words offered, memory stops at DEPTH.
        applyStimulus(1, 0, 0, 0, 32'h0, BASE);
        for (int i = 0; i < 70; i++) begin
            words[i] = $urandom;
            applyStimulus(0, 1, 1, 0, words[i], BASE);
            if (i == 63) check("full_load_ready", 32'(load_ready), 32'd0);
        end
        check("full_count", 32'(words_loaded), 32'd64);
        check("full_ready", 32'(prog_ready), 32'd1);
        fetchExpect("fetch_w63", BASE + 32'hFC, words[63]);
        check("w63_nofault", 32'(addr_fault), 32'd0);

        // Randomized sessions checked against the reference every cycle.
        for (int r = 0; r < 20; r++) begin
            applyStimulus(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, $urandom, BASE);
            for (int c = 0; c < 40; c++) begin
                randomAddr(addr);
                applyStimulus(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                              ($urandom_range(0, 11) == 0), $urandom, addr);
            end
            for (int c = 0; c < 30; c++) begin
                randomAddr(addr);
                applyStimulus(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), 0, $urandom, addr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_memory.md
INSTR_MEMORY -- requirements
Module: instr_memory

Interface
REQ-001 Parameter DEPTH, default 64, instruction words held (power of two, 4..1024).
REQ-002 Parameter BASE, default 32'hBFC00000, byte address of word 0 (reset vector).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clk_enable  input  1  when 0, all state holds; combinational read path still valid.
REQ-006 load_valid  input  1  loader offers a program word.
REQ-007 load_data  input  32  program word, stored in ascending address order from BASE.
REQ-008 load_last  input  1  qualifies final word of program; meaningful only with load_valid.
REQ-009 load_ready  output  1  memory accepts a word this cycle.
REQ-010 instr_address  input  32  CPU fetch byte address.
REQ-011 instr_readdata  output  32  CPU fetch data, combinational from instr_address.
REQ-012 prog_ready  output  1  program loaded; fetches served.
REQ-013 addr_fault  output  1  sticky flag: illegal fetch seen while prog_ready.
REQ-014 words_loaded  output  $clog2(DEPTH)+1  count of accepted words.

Function
REQ-015 FSM states IDLE, LOAD, READY; reset enters IDLE.
REQ-016 Handshake: word accepted on a rising edge with load_valid and load_ready and clk_enable all 1.
REQ-017 load_ready = 1 in IDLE and LOAD, 0 in READY.
REQ-018 IDLE -> LOAD on first accepted word without load_last; IDLE -> READY if that word carries load_last.
REQ-019 LOAD -> READY on accepted word with load_last, or when the accepted word makes words_loaded equal DEPTH.
REQ-020 READY is terminal until reset; load_valid ignored, no write, count holds.
REQ-021 Accepted word k (0-based) is written to mem[k]; words_loaded increments by 1 the same edge.
REQ-022 prog_ready = 1 exactly in READY, asserted the cycle after the final accepting edge.
REQ-023 Fetch index = (instr_address - BASE) >> 2, 32-bit modulo subtraction.
REQ-024 instr_readdata = mem[index] iff prog_ready, instr_address[1:0]==0, index < words_loaded; otherwise 32'h0 (NOP).
REQ-025 instr_address == 0 (CPU halt address) returns 32'h0 and is never a fault.
REQ-026 Fault condition: prog_ready, instr_address != 0, and (misaligned or index >= DEPTH); sampled at a clk_enable edge, addr_fault set the following cycle, held until reset.
REQ-027 Address inside loaded range but index in [words_loaded, DEPTH) returns 0 without fault.
REQ-028 Memory contents are not cleared by reset; reads gated by words_loaded per REQ-024.

Reset
REQ-029 reset = 1 at an edge: state IDLE, words_loaded 0, addr_fault 0, prog_ready 0, load_ready 1; reset dominates clk_enable and load_valid.
REQ-030 Reset mid-LOAD discards partial program; next accepted word is written to mem[0].

Structure
REQ-031 Shared package mem_pkg holds RESET_VECTOR (32'hBFC00000), HALT_ADDR (32'h0), NOP (32'h0) and the state enum type.
REQ-032 One sub-module, instr_loader_fsm, owns state, count and handshake; storage and read mux stay in instr_memory.

Verification
REQ-033 Load 16 words (0x24010020, ...) with load_last on the 16th -> words_loaded 16, prog_ready 1 next cycle, fetch 0xBFC00008 returns word 2.
REQ-034 Stall: load_valid held 1, clk_enable toggled 1/0 for 8 cycles -> exactly 4 words accepted, written to mem[0..3].
REQ-035 DEPTH=64, 70 words offered without load_last -> 64 accepted, load_ready 0 after the 64th, prog_ready 1; fetch 0xBFC000FC returns word 63.
REQ-036 After READY: fetch 0xBFC00002 -> readdata 0, addr_fault 1 next cycle; fetch 0x00000000 -> readdata 0, no new fault; fetch 0xBFC00040 with 16 words loaded -> readdata 0, no fault.
REQ-037 Reset asserted after 5 of 10 words -> IDLE, words_loaded 0; reload 3 words with load_last -> fetch 0xBFC00000 returns new word 0.
REQ-038 Fetch before prog_ready at 0xBFC00000 -> readdata 0, addr_fault stays 0.
